// File: rtl/adc_stereo_sequencer.sv
// Free-running SPI frame sequencer for an 8-channel 12-bit serial ADC; alternates left/right
// channel requests and publishes each pipelined result to the side that requested it.
module adc_stereo_sequencer #(
  parameter int SCLK_DIV     = 25,
  parameter int FRAME_PERIOD = 1000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        enable,
  input  logic [5:0]  ch_cfg,
  output logic        adc_sclk,
  output logic        adc_cs_n,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [31:0] links_data,
  output logic [31:0] rechts_data,
  output logic        links_valid,
  output logic        rechts_valid,
  output logic        busy
);

  localparam int CNT_W = $clog2(2 * SCLK_DIV);
  localparam int TMR_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  // CS setup and hold guards are one full SCLK period each, so a frame spans 36 half-periods.
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(2 * SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(SCLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(FRAME_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, WAIT} state_t;

  state_t            state, state_nx;
  logic [TMR_W-1:0]  tmr, tmr_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [4:0]        half, half_nx;
  logic              sclk_q, sclk_nx;
  logic              cs_n_q, cs_n_nx;
  logic              din_q, din_nx;
  logic [11:0]       shreg, shreg_nx;
  logic [2:0]        addr, addr_nx;
  logic              sel, sel_nx;
  logic              req, req_nx;
  logic              owner, owner_nx;
  logic              prime, prime_nx;
  logic [31:0]       links_nx, rechts_nx;
  logic              lv_nx, rv_nx;
  logic              start;

  // Address bits ADD2..ADD0 occupy serial bit positions 2..4 (b=13..11).
  function automatic logic din_bit(input logic [2:0] a, input logic [3:0] idx);
    case (idx)
      4'd2:    din_bit = a[2];
      4'd3:    din_bit = a[1];
      4'd4:    din_bit = a[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    half_nx   = half;
    sclk_nx   = sclk_q;
    cs_n_nx   = cs_n_q;
    din_nx    = din_q;
    shreg_nx  = shreg;
    addr_nx   = addr;
    sel_nx    = sel;
    req_nx    = req;
    owner_nx  = owner;
    prime_nx  = prime;
    links_nx  = links_data;
    rechts_nx = rechts_data;
    lv_nx     = 1'b0;
    rv_nx     = 1'b0;
    start     = 1'b0;
    if (state == IDLE || tmr == TMR_LAST) tmr_nx = '0;
    else                                  tmr_nx = tmr + TMR_W'(1);

    case (state)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      SETUP: begin
        if (cnt == GUARD_LAST) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          half_nx  = '0;
          sclk_nx  = 1'b0;
          din_nx   = din_bit(addr, 4'd0);
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (!half[0]) begin
            sclk_nx = 1'b1;
            half_nx = half + 5'd1;
            // Leading four bits (b15..b12) carry no conversion data.
            if (half[4:1] >= 4'd4) shreg_nx = {shreg[10:0], adc_dout};
          end else if (half == 5'd31) begin
            state_nx = HOLD;
            din_nx   = 1'b0;
          end else begin
            half_nx = half + 5'd1;
            sclk_nx = 1'b0;
            din_nx  = din_bit(addr, half[4:1] + 4'd1);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt == GUARD_LAST) begin
          state_nx = WAIT;
          cnt_nx   = '0;
          cs_n_nx  = 1'b1;
          sel_nx   = ~sel;
          if (prime) begin
            prime_nx = 1'b0;
          end else if (owner) begin
            rechts_nx = {20'b0, shreg};
            rv_nx     = 1'b1;
          end else begin
            links_nx = {20'b0, shreg};
            lv_nx    = 1'b1;
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      WAIT: begin
        if (tmr == TMR_LAST) begin
          if (enable) begin
            start = 1'b1;
          end else begin
            state_nx = IDLE;
            prime_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    // The ADC answers one frame late, so this frame's result belongs to the previous request.
    if (start) begin
      state_nx = SETUP;
      cnt_nx   = '0;
      cs_n_nx  = 1'b0;
      addr_nx  = sel ? ch_cfg[5:3] : ch_cfg[2:0];
      req_nx   = sel;
      owner_nx = req;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state        <= IDLE;
      tmr          <= '0;
      cnt          <= '0;
      half         <= '0;
      sclk_q       <= 1'b1;
      cs_n_q       <= 1'b1;
      din_q        <= 1'b0;
      shreg        <= '0;
      addr         <= '0;
      sel          <= 1'b0;
      req          <= 1'b0;
      owner        <= 1'b0;
      prime        <= 1'b1;
      links_data   <= '0;
      rechts_data  <= '0;
      links_valid  <= 1'b0;
      rechts_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      tmr          <= tmr_nx;
      cnt          <= cnt_nx;
      half         <= half_nx;
      sclk_q       <= sclk_nx;
      cs_n_q       <= cs_n_nx;
      din_q        <= din_nx;
      shreg        <= shreg_nx;
      addr         <= addr_nx;
      sel          <= sel_nx;
      req          <= req_nx;
      owner        <= owner_nx;
      prime        <= prime_nx;
      links_data   <= links_nx;
      rechts_data  <= rechts_nx;
      links_valid  <= lv_nx;
      rechts_valid <= rv_nx;
    end
  end

  assign adc_sclk = sclk_q;
  assign adc_cs_n = cs_n_q;
  assign adc_din  = din_q;
  assign busy     = ~cs_n_q;

endmodule
